dmem_port_arbiter: RTL
======================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-port data memory between the pipeline MEM stage (CPU port)
//  and the program/data loader DMA port. Fixed CPU priority plus a starvation guard for DMA.
//  Sits between the MEM stage/loader and the data memory.
//  Drives the memory's WE/address/WD and registers read data back to the granted requester.
// PARAMETERS
//  DEPTH        100  number of 32-bit words in data memory; legal addr 0..DEPTH-1
//  AW           32   address width of both requester ports and mem_addr
//  STARVE_LIMIT 4    consecutive lost cycles after which DMA is forced to win (1..15)
// PORTS
//  clk         in   1   clock, all state on rising edge
//  rst         in   1   asynchronous, active-low reset
//  cpu_req     in   1   CPU access request (held until cpu_gnt)
//  cpu_we      in   1   1=write, 0=read
//  cpu_addr    in   AW  word address
//  cpu_wdata   in   32  write data
//  cpu_gnt     out  1   combinational grant; access performed this cycle
//  cpu_rvalid  out  1   registered pulse: cpu_rdata valid (read grants only)
//  cpu_rdata   out  32  registered read data
//  dma_req/dma_we/dma_addr/dma_wdata   in   same as CPU port
//  dma_gnt/dma_rvalid/dma_rdata        out  same as CPU port
//  mem_we      out  1   write enable to data memory
//  mem_addr    out  AW  address to data memory
//  mem_wd      out  32  write data to data memory
//  mem_rd      in   32  combinational read data from data memory
//  addr_err    out  1   registered pulse: granted access had addr >= DEPTH
// BEHAVIOUR
//  Reset (rst=0, async): all gnt/rvalid/addr_err=0, rdata=0, starve_cnt=0, state=PRI_CPU.
//   While rst=0, gnt outputs and mem_we are forced to 0.
//  FSM (priority state):
//   PRI_CPU: CPU wins on contention.
//   PRI_DMA: DMA wins on contention.
//   PRI_CPU -> PRI_DMA when starve_cnt reaches STARVE_LIMIT.
//   PRI_DMA -> PRI_CPU on the edge following any dma_gnt.
//  starve_cnt: +1 each cycle with dma_req=1 and dma_gnt=0 (saturates at STARVE_LIMIT).
//   Cleared when dma_gnt=1 or dma_req=0.
//  Grant (combinational, same cycle): at most one gnt high per cycle.
//   Single requester is always granted; with both requesting, the FSM state decides.
//  Muxing: mem_addr/mem_wd follow the granted port, else the CPU port.
//   mem_we = granted_we & addr_in_range; out-of-range writes are suppressed.
//  Read response: on the edge after a read grant, <port>_rvalid=1 for exactly 1 cycle.
//   <port>_rdata = mem_rd sampled at grant, or 0 if out of range.
//   rdata holds its value until the next read response on that port.
//   Latency: 1 cycle from gnt to rvalid.
//  Writes produce no rvalid; memory updates on the same edge (mem_we).
//  addr_err: 1-cycle pulse on the edge after any granted out-of-range access.
//  Back-to-back grants to the same port in consecutive cycles are allowed (full throughput).
//  No request cycles: mem_we=0, no state change except starve_cnt clear.
//  Reset mid-access: a pending rvalid/addr_err is dropped; req must be re-presented.
// TESTING
//  1 CPU-only read addr 5 (mem=0xA5A5_0005) -> cpu_gnt same cycle, cpu_rvalid next cycle,
//    cpu_rdata=0xA5A5_0005, dma_gnt=0.
//  2 DMA write addr 7 data 0x1234 then DMA read addr 7 -> mem_we=1 once, dma_rdata=0x1234.
//  3 Both req continuously, STARVE_LIMIT=4 -> grant pattern CPU,CPU,CPU,CPU,DMA, repeating;
//    never both gnt high.
//  4 CPU write addr 100 (DEPTH=100) -> cpu_gnt=1, mem_we=0, addr_err pulse next cycle;
//    read addr 150 -> rdata=0.
//  5 Assert rst=0 in the cycle after a read grant -> rvalid stays 0, starve_cnt=0, state=PRI_CPU.
//  6 dma_req drops after 3 lost cycles then returns -> starve_cnt restarts at 0;
//    DMA first wins after 4 more lost cycles.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the CPU port, DMA port and data-memory side of the dmem port arbiter.
// slave = arbiter view, master = requester/memory view.
interface dmem_port_arbiter_if #(
  parameter int AW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [31:0]   cpu_rdata;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [31:0]   dma_wdata;
  logic          dma_gnt;
  logic          dma_rvalid;
  logic [31:0]   dma_rdata;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wd;
  logic [31:0]   mem_rd;
  logic          addr_err;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_we, mem_addr, mem_wd, addr_err,
    input  mem_rd
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_we, mem_addr, mem_wd, addr_err,
    output mem_rd
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the MEM-stage CPU port and the loader DMA port.
// CPU has fixed priority; a starvation counter hands DMA one win after STARVE_LIMIT lost cycles.
module dmem_port_arbiter #(
  parameter int DEPTH        = 100,
  parameter int AW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 rst,
  dmem_port_arbiter_if.slave  bus
);

  typedef enum logic {
    PRI_CPU = 1'b0,
    PRI_DMA = 1'b1
  } pri_e;

  localparam logic [3:0]    LIMIT   = 4'(STARVE_LIMIT);
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  pri_e        state_q;
  logic [3:0]  starve_q, starve_d;
  logic        cpu_rvalid_q, dma_rvalid_q, addr_err_q;
  logic [31:0] cpu_rdata_q, dma_rdata_q;

  logic        cpu_gnt, dma_gnt, any_gnt, gnt_we, in_range;
  logic [AW-1:0] sel_addr;

  // Grant decision: single requester always wins, contention settled by priority state.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (rst) begin
      if (bus.cpu_req && bus.dma_req) begin
        if (state_q == PRI_DMA) dma_gnt = 1'b1;
        else                    cpu_gnt = 1'b1;
      end else if (bus.cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (bus.dma_req) begin
        dma_gnt = 1'b1;
      end
    end
  end

  assign any_gnt  = cpu_gnt | dma_gnt;
  assign sel_addr = dma_gnt ? bus.dma_addr : bus.cpu_addr;
  assign gnt_we   = dma_gnt ? bus.dma_we   : bus.cpu_we;
  assign in_range = (sel_addr < DEPTH_A);

  // Out-of-range writes never reach the memory.
  assign bus.mem_addr = sel_addr;
  assign bus.mem_wd   = dma_gnt ? bus.dma_wdata : bus.cpu_wdata;
  assign bus.mem_we   = any_gnt & gnt_we & in_range;

  always_comb begin
    starve_d = 4'd0;
    if (bus.dma_req && !dma_gnt) begin
      starve_d = (starve_q >= LIMIT) ? LIMIT : starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= PRI_CPU;
      starve_q     <= 4'd0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      addr_err_q   <= 1'b0;
      cpu_rdata_q  <= 32'd0;
      dma_rdata_q  <= 32'd0;
    end else begin
      starve_q <= starve_d;
      case (state_q)
        PRI_CPU: if (starve_d >= LIMIT) state_q <= PRI_DMA;
        PRI_DMA: if (dma_gnt)           state_q <= PRI_CPU;
        default:                        state_q <= PRI_CPU;
      endcase

      cpu_rvalid_q <= cpu_gnt & ~bus.cpu_we;
      dma_rvalid_q <= dma_gnt & ~bus.dma_we;
      addr_err_q   <= any_gnt & ~in_range;

      // rdata only moves on a read response and reads as zero when out of range.
      if (cpu_gnt && !bus.cpu_we) cpu_rdata_q <= in_range ? bus.mem_rd : 32'd0;
      if (dma_gnt && !bus.dma_we) dma_rdata_q <= in_range ? bus.mem_rd : 32'd0;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dma_gnt    = dma_gnt;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.dma_rvalid = dma_rvalid_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.dma_rdata  = dma_rdata_q;
  assign bus.addr_err   = addr_err_q;

endmodule
